mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
Parametrised MEM/WB pipeline register for the 5-stage core, successor to the fixed-width MEM/WB flop bank. It carries N data lanes, write-back control and the destination register from MEM to WB. Adds a valid bit, an explicit flush, a selectable stall policy, an integrated write-back select mux, a forwarding view and saturating stall/bubble counters. Sits between the memory stage and the register-file write port; forwarding outputs feed the hazard/bypass unit.

Parameters:
DATA_W, 16, width of each data lane
NUM_LANES, 4, number of data lanes; lane 0 = memory read data, 1 = ALU result, 2 = PC+2, 3 = Binput
SRC_W, 2, width of the write-back source select; must satisfy 2**SRC_W >= NUM_LANES
REG_ADDR_W, 3, destination register address width
STALL_MODE, 0, 0 = hold (freeze all state on stall); 1 = bubble-on-stall (fields advance, write enable and valid forced low)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall_in  in  1  stall request (memory stall OR fetch stall, ORed by the caller)
flush_in  in  1  squash the instruction entering WB
valid_in  in  1  MEM stage holds a real instruction
data_in  in  NUM_LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
reg_src_in  in  SRC_W  write-back lane select
reg_wrt_in  in  1  register write enable
write_reg_in  in  REG_ADDR_W  destination register
nop_in  in  1  instruction is a NOP
branch_in  in  1  branch-taken marker
valid_out  out  1  WB holds a real instruction
data_out  out  NUM_LANES*DATA_W  registered lanes
reg_src_out  out  SRC_W  registered select
reg_wrt_out  out  1  register-file write enable
write_reg_out  out  REG_ADDR_W  registered destination
nop_out  out  1  registered NOP marker
branch_out  out  1  registered branch marker
wb_data  out  DATA_W  selected write-back data
fwd_valid  out  1  WB result is forwardable
stall_cnt  out  CNT_W  cycles with stall applied
bubble_cnt  out  CNT_W  bubbles loaded into WB

Behaviour:
- Latency: one cycle, MEM inputs to outputs. Update priority per edge: rst > flush_in > stall_in > normal load.
- Reset: every registered output and both counters go to 0. nop_out = 0, valid_out = 0.
- Flush (regardless of stall or STALL_MODE): valid_out = 0, reg_wrt_out = 0, branch_out = 0, nop_out = 1. data_out, reg_src_out and write_reg_out load 0.
- Stall, STALL_MODE=0: every register holds its value, counters excepted.
- Stall, STALL_MODE=1: data_out, reg_src_out, write_reg_out, nop_out and branch_out load their inputs. reg_wrt_out = 0 and valid_out = 0. This preserves the legacy bubble-on-stall semantics.
- Normal load: all fields load their inputs. valid_out = valid_in. reg_wrt_out = reg_wrt_in & valid_in. branch_out = branch_in & valid_in.
- wb_data: combinational. Selects lane reg_src_out of data_out; if reg_src_out >= NUM_LANES it is 0. It does not depend on any input port.
- fwd_valid: combinational, equal to valid_out & reg_wrt_out & ~nop_out. No register-0 special case; all registers are writable.
- stall_cnt: +1 on each edge where stall_in=1, flush_in=0 and rst=0. It saturates at all-ones and does not wrap.
- bubble_cnt: +1 on each edge where the newly loaded valid_out is 0, i.e. flush, stall under STALL_MODE=1, or normal load with valid_in=0. It saturates at all-ones. Under STALL_MODE=0 a held stall cycle does not count.
- Simultaneous flush and stall: flush wins. stall_cnt does not increment; bubble_cnt does.
- Reset asserted mid-stall or mid-flush: reset wins and clears everything, including the counters.

Test Plan:
- Reset then normal load: valid_in=1, reg_wrt_in=1, write_reg_in=3'd5, lanes {0x1111,0x2222,0x3333,0x4444}, reg_src_in=1 -> next cycle valid_out=1, reg_wrt_out=1, write_reg_out=5, wb_data=0x2222, fwd_valid=1.
- STALL_MODE=0, stall_in=1 for 3 cycles with inputs changing -> outputs frozen at prior values, stall_cnt=3, bubble_cnt=0.
- STALL_MODE=1, stall_in=1 with reg_wrt_in=1, lane1=0xBEEF, reg_src_in=1 -> reg_wrt_out=0, valid_out=0, wb_data=0xBEEF, fwd_valid=0, bubble_cnt +1.
- flush_in=1 and stall_in=1 together -> valid_out=0, nop_out=1, reg_wrt_out=0, wb_data=0, stall_cnt unchanged, bubble_cnt +1.
- valid_in=0 with reg_wrt_in=1 and branch_in=1 -> reg_wrt_out=0, branch_out=0, bubble_cnt +1. Separately, reg_src_in=3 with NUM_LANES=3 -> wb_data=0.
- CNT_W=4, stall held 20 cycles -> stall_cnt reaches 4'hF and stays there. Then assert rst for 1 cycle -> stall_cnt=0 and all outputs 0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: N data lanes, write-back control, valid/flush,
// selectable stall policy, write-back mux, forwarding view and perf counters.
module mem_wb_stage #(
    parameter int DATA_W     = 16,
    parameter int NUM_LANES  = 4,
    parameter int SRC_W      = 2,
    parameter int REG_ADDR_W = 3,
    parameter int STALL_MODE = 0,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall_in,
    input  logic                        flush_in,
    input  logic                        valid_in,
    input  logic [NUM_LANES*DATA_W-1:0] data_in,
    input  logic [SRC_W-1:0]            reg_src_in,
    input  logic                        reg_wrt_in,
    input  logic [REG_ADDR_W-1:0]       write_reg_in,
    input  logic                        nop_in,
    input  logic                        branch_in,
    output logic                        valid_out,
    output logic [NUM_LANES*DATA_W-1:0] data_out,
    output logic [SRC_W-1:0]            reg_src_out,
    output logic                        reg_wrt_out,
    output logic [REG_ADDR_W-1:0]       write_reg_out,
    output logic                        nop_out,
    output logic                        branch_out,
    output logic [DATA_W-1:0]           wb_data,
    output logic                        fwd_valid,
    output logic [CNT_W-1:0]            stall_cnt,
    output logic [CNT_W-1:0]            bubble_cnt
);

    localparam bit BUBBLE = (STALL_MODE != 0);

    logic                        valid_q, valid_d;
    logic [NUM_LANES*DATA_W-1:0] data_q, data_d;
    logic [SRC_W-1:0]            src_q, src_d;
    logic                        wrt_q, wrt_d;
    logic [REG_ADDR_W-1:0]       wreg_q, wreg_d;
    logic                        nop_q, nop_d;
    logic                        br_q, br_d;
    logic [CNT_W-1:0]            scnt_q, scnt_d;
    logic [CNT_W-1:0]            bcnt_q, bcnt_d;
    logic                        bubble;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        src_d   = src_q;
        wrt_d   = wrt_q;
        wreg_d  = wreg_q;
        nop_d   = nop_q;
        br_d    = br_q;
        bubble  = 1'b0;
        if (flush_in) begin
            valid_d = 1'b0;
            data_d  = '0;
            src_d   = '0;
            wrt_d   = 1'b0;
            wreg_d  = '0;
            nop_d   = 1'b1;
            br_d    = 1'b0;
            bubble  = 1'b1;
        end else if (stall_in) begin
            // Bubble policy lets fields flow but kills the write.
            if (BUBBLE) begin
                valid_d = 1'b0;
                data_d  = data_in;
                src_d   = reg_src_in;
                wrt_d   = 1'b0;
                wreg_d  = write_reg_in;
                nop_d   = nop_in;
                br_d    = branch_in;
                bubble  = 1'b1;
            end
        end else begin
            valid_d = valid_in;
            data_d  = data_in;
            src_d   = reg_src_in;
            wrt_d   = reg_wrt_in & valid_in;
            wreg_d  = write_reg_in;
            nop_d   = nop_in;
            br_d    = branch_in & valid_in;
            bubble  = ~valid_in;
        end
    end

    always_comb begin
        scnt_d = scnt_q;
        bcnt_d = bcnt_q;
        if (stall_in && !flush_in && scnt_q != '1)
            scnt_d = scnt_q + 1'b1;
        if (bubble && bcnt_q != '1)
            bcnt_d = bcnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= '0;
            wrt_q   <= 1'b0;
            wreg_q  <= '0;
            nop_q   <= 1'b0;
            br_q    <= 1'b0;
            scnt_q  <= '0;
            bcnt_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            src_q   <= src_d;
            wrt_q   <= wrt_d;
            wreg_q  <= wreg_d;
            nop_q   <= nop_d;
            br_q    <= br_d;
            scnt_q  <= scnt_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // Out-of-range select yields zero.
    always_comb begin
        wb_data = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (int'(src_q) == i)
                wb_data = data_q[i*DATA_W +: DATA_W];
        end
    end

    assign valid_out     = valid_q;
    assign data_out      = data_q;
    assign reg_src_out   = src_q;
    assign reg_wrt_out   = wrt_q;
    assign write_reg_out = wreg_q;
    assign nop_out       = nop_q;
    assign branch_out    = br_q;
    assign fwd_valid     = valid_q & wrt_q & ~nop_q;
    assign stall_cnt     = scnt_q;
    assign bubble_cnt    = bcnt_q;

endmodule
